// File: rtl/fpr_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// fpr_addsub_arbiter
//
// Shares a single combinational IEEE-754 single-precision adder (fpr_add)
// between two requesters. A round-robin arbiter picks one request in IDLE.
// Its operands are registered (EXEC), the adder result is registered into the
// response register, and the response is then held (RESP) until the consumer
// takes it. The adder therefore sits between two flops and closes in one cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req0_* / req1_*          request ports: valid, ready, a, b, adsb (0 add, 1 sub)
//   resp_valid/resp_ready    response handshake
//   resp_id                  requester index that owns resp_data
//   resp_data                adder result
//   busy                     high whenever the FSM is not in IDLE
//   op_count                 completed-operation counter (wraps at 2^CNT_W)
//
// Handshake rule for every port: a transfer happens on a rising clk edge where
// valid and ready are both high. A requester holds valid and its operands
// stable until ready. Ready is only ever offered to one requester at a time,
// and only in IDLE.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// fpr_add: combinational single-precision add/subtract, round-to-nearest-even.
//   C    result
//   a    operand A
//   b    operand B
//   adsb 0: C = a + b, 1: C = a - b
// Subnormals are handled with their true value. Infinities propagate, and
// NaN inputs or inf - inf produce the canonical quiet NaN.
// -----------------------------------------------------------------------------
module fpr_add (
    output logic [31:0] C,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        adsb
);
    logic [31:0] b_eff;
    logic        swap;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex_raw;
    logic [7:0]  ey_raw;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [23:0] mx;
    logic [23:0] my;
    logic [7:0]  diff;
    logic [4:0]  shamt;
    logic [53:0] wide;
    logic [26:0] my_al;
    logic        sub;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [7:0]  lz8;
    logic [7:0]  ex_m1;
    logic [7:0]  shift8;
    logic [26:0] norm;
    logic [9:0]  exp_n;
    logic [9:0]  exp_f;
    logic        rup;
    logic [24:0] mr;
    logic [22:0] frac_f;

    // Position of the highest set bit, counted from bit 26; 27 when zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end
        end
        return n;
    endfunction

    // Order the operands so |x| >= |y|; the result sign then follows x.
    assign b_eff  = {b[31] ^ adsb, b[30:0]};
    assign swap   = (b_eff[30:0] > a[30:0]);
    assign x      = swap ? b_eff : a;
    assign y      = swap ? a : b_eff;
    assign ex_raw = x[30:23];
    assign ey_raw = y[30:23];
    // Subnormals use exponent 1 with no hidden bit.
    assign ex     = (ex_raw == 8'd0) ? 8'd1 : ex_raw;
    assign ey     = (ey_raw == 8'd0) ? 8'd1 : ey_raw;
    assign mx     = {(ex_raw != 8'd0), x[22:0]};
    assign my     = {(ey_raw != 8'd0), y[22:0]};
    assign diff   = ex - ey;
    assign shamt  = (diff > 8'd27) ? 5'd27 : diff[4:0];

    // Align y with three extra bits (guard, round, sticky). Bits shifted past
    // the sticky position collapse into it.
    assign wide   = {my, 3'b000, 27'd0} >> shamt;
    assign my_al  = {wide[53:28], wide[27] | (|wide[26:0])};
    assign sub    = x[31] ^ y[31];
    assign sum    = sub ? ({1'b0, mx, 3'b000} - {1'b0, my_al})
                        : ({1'b0, mx, 3'b000} + {1'b0, my_al});

    assign lz     = lzc27(sum[26:0]);
    assign lz8    = {3'b000, lz};
    assign ex_m1  = ex - 8'd1;
    // Left-normalise no further than the minimum exponent (subnormal result).
    assign shift8 = (lz8 < ex_m1) ? lz8 : ex_m1;

    always_comb begin
        norm  = 27'd0;
        exp_n = 10'd0;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, ex} + 10'd1;
        end else begin
            norm  = sum[26:0] << shift8;
            exp_n = {2'b00, ex} - {2'b00, shift8};
            if (!norm[26]) begin
                exp_n = 10'd0;
            end
        end
    end

    assign rup = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mr  = {1'b0, norm[26:3]} + {24'd0, rup};

    always_comb begin
        exp_f  = exp_n;
        frac_f = mr[22:0];
        if (mr[24]) begin
            exp_f  = exp_n + 10'd1;
            frac_f = mr[23:1];
        end else if ((exp_n == 10'd0) && mr[23]) begin
            // Rounding carried a subnormal into the smallest normal.
            exp_f = 10'd1;
        end
    end

    always_comb begin
        C = {x[31], exp_f[7:0], frac_f};
        if (ex_raw == 8'hFF) begin
            if ((x[22:0] != 23'd0) || ((ey_raw == 8'hFF) && sub)) begin
                C = 32'h7FC0_0000;
            end else begin
                C = {x[31], 8'hFF, 23'd0};
            end
        end else if (sum == 28'd0) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            C = {x[31] & y[31], 31'd0};
        end else if (exp_f >= 10'd255) begin
            C = {x[31], 8'hFF, 23'd0};
        end
    end
endmodule

module fpr_addsub_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_adsb,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_adsb,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic             op_adsb_q;
    logic             op_id_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [31:0]      resp_data_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    logic             grant0;
    logic             grant1;
    logic             idle;
    logic [31:0]      add_c;

    // Round robin: a lone requester wins; on contention the one that was not
    // granted last time wins.
    assign idle       = (state_q == ST_IDLE);
    assign grant0     = req0_valid & (~req1_valid | last_grant_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = idle & grant0;
    assign req1_ready = idle & grant1;
    assign op_count_d = op_count_q + 1'b1;

    fpr_add u_fpr_add (
        .C    (add_c),
        .a    (op_a_q),
        .b    (op_b_q),
        .adsb (op_adsb_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            op_adsb_q    <= 1'b0;
            op_id_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 32'd0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a_q       <= req1_ready ? req1_a : req0_a;
                        op_b_q       <= req1_ready ? req1_b : req0_b;
                        op_adsb_q    <= req1_ready ? req1_adsb : req0_adsb;
                        op_id_q      <= req1_ready;
                        last_grant_q <= req1_ready;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data_q  <= add_c;
                    resp_id_q    <= op_id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_fpr_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for fpr_addsub_arbiter: directed cases followed by randomized traffic.
// Expected results come from a real-number model of IEEE single add/sub with
// round-to-nearest-even, and a round-robin model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_fpr_addsub_arbiter;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic             req0_adsb;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic             req1_adsb;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [31:0]      resp_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    logic [32:0]      exp_q[$];
    logic [CNT_W-1:0] exp_count;
    int               last_m;
    int               acc_cyc;

    fpr_addsub_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_adsb  (req0_adsb),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_adsb  (req1_adsb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .op_count   (op_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'd0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        logic [28:0] rem;
        if (r == 0.0) return 32'h0;
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 896;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    // Operands are kept normal with an exponent gap small enough that the
    // double-precision sum is exact, so only one rounding step happens.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        real r;
        r = s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        return r2f(r);
    endfunction

    function automatic int winner(input logic v0, input logic v1);
        if (v0 && v1) return 1 - last_m;
        return v0 ? 0 : 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_req(input int idx, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic s);
        if (idx == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_adsb = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_adsb = s;
        end
    endtask

    // Called after request inputs are driven (just after an edge): checks the
    // grant, records the expected response and takes the accept edge.
    task automatic do_accept(input int exp_win, input logic [31:0] exp_data);
        #1;
        check("rdy0", req0_ready, (exp_win == 0));
        check("rdy1", req1_ready, (exp_win == 1));
        check("idle_busy", busy, 0);
        check("idle_rvalid", resp_valid, 0);
        exp_q.push_back({exp_win[0], exp_data});
        last_m = exp_win;
        tick();
        acc_cyc = cyc;
    endtask

    // Runs from the EXEC cycle through the response handshake, holding
    // resp_ready low for `stall` cycles first.
    task automatic serve_resp(input int stall);
        logic [32:0] e;
        check("exec_rvalid", resp_valid, 0);
        check("exec_busy", busy, 1);
        check("exec_rdy0", req0_ready, 0);
        check("exec_rdy1", req1_ready, 0);
        tick();
        e = exp_q.pop_front();
        for (int k = 0; k <= stall; k++) begin
            resp_ready = (k == stall);
            #1;
            check("resp_valid", resp_valid, 1);
            check("resp_data", resp_data, e[31:0]);
            check("resp_id", resp_id, e[32]);
            check("resp_rdy0", req0_ready, 0);
            check("resp_rdy1", req1_ready, 0);
            check("resp_busy", busy, 1);
            tick();
        end
        resp_ready = 1'b0;
        exp_count  = exp_count + 1'b1;
        check("post_rvalid", resp_valid, 0);
        check("post_busy", busy, 0);
        check("op_count", op_count, exp_count);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_count = '0;
        last_m = 1;
        exp_q.delete();
    endtask

    function automatic logic [31:0] rand_fp(input int e);
        logic [31:0] rv;
        rv = $urandom();
        return {rv[31], 8'(e), rv[22:0]};
    endfunction

    // ---------------- stimulus ----------------
    logic        p_v[2];
    logic [31:0] p_a[2];
    logic [31:0] p_b[2];
    logic        p_s[2];

    task automatic new_op(input int i);
        int          ea;
        int          mode;
        logic [31:0] rv;
        ea     = $urandom_range(100, 150);
        mode   = $urandom_range(0, 7);
        p_a[i] = rand_fp(ea);
        p_s[i] = 1'($urandom_range(0, 1));
        if (mode == 0) begin
            p_b[i] = p_a[i];
        end else if (mode == 1) begin
            rv     = $urandom();
            p_b[i] = {p_a[i][31:4], rv[3:0]};
        end else begin
            p_b[i] = rand_fp(ea + $urandom_range(0, 40) - 20);
        end
        p_v[i] = 1'b1;
    endtask

    initial begin
        int prev_acc;
        int w;
        rst = 1'b1;
        resp_ready = 1'b0;
        drive_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        do_reset();
        #1;
        check("rst_rvalid", resp_valid, 0);
        check("rst_rid", resp_id, 0);
        check("rst_rdata", resp_data, 0);
        check("rst_count", op_count, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);

        // 1: requester 0 alone
        drive_req(0, 1'b1, 32'h443C_B6A8, 32'h447D_37F0, 1'b0);
        do_accept(0, 32'h44DC_F74C);
        drive_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        serve_resp(0);

        // 2: requester 1 alone, subtraction with cancellation
        drive_req(1, 1'b1, 32'h431A_399A, 32'h431A_43D7, 1'b1);
        do_accept(1, 32'hBD23_D000);
        drive_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        serve_resp(0);

        // 3: both requesting continuously -> alternating grants, 3 cycles each
        new_op(0);
        new_op(1);
        prev_acc = -1;
        for (int n = 0; n < 4; n++) begin
            drive_req(0, 1'b1, p_a[0], p_b[0], p_s[0]);
            drive_req(1, 1'b1, p_a[1], p_b[1], p_s[1]);
            w = winner(1'b1, 1'b1);
            check("rr_order", w, n % 2);
            do_accept(w, ref_add(p_a[w], p_b[w], p_s[w]));
            if (prev_acc >= 0) check("rr_period", acc_cyc - prev_acc, 3);
            prev_acc = acc_cyc;
            new_op(w);
            drive_req(w, 1'b1, p_a[w], p_b[w], p_s[w]);
            serve_resp(0);
        end
        drive_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        // 4: backpressure on the response
        new_op(0);
        drive_req(0, 1'b1, p_a[0], p_b[0], p_s[0]);
        do_accept(0, ref_add(p_a[0], p_b[0], p_s[0]));
        drive_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        serve_resp(5);

        // 5: reset during EXEC discards the op and restores fairness state
        do_reset();
        new_op(0);
        new_op(1);
        drive_req(0, 1'b1, p_a[0], p_b[0], p_s[0]);
        drive_req(1, 1'b1, p_a[1], p_b[1], p_s[1]);
        do_accept(0, ref_add(p_a[0], p_b[0], p_s[0]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        last_m = 1;
        check("mid_rst_rvalid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", op_count, 0);
        do_accept(0, ref_add(p_a[0], p_b[0], p_s[0]));
        drive_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        serve_resp(0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        // 6: counter wrap
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        tick();
        release dut.op_count_q;
        #1;
        check("preload_count", op_count, 32'hFFFF);
        exp_count = 16'hFFFF;
        new_op(1);
        drive_req(1, 1'b1, p_a[1], p_b[1], p_s[1]);
        do_accept(winner(1'b0, 1'b1), ref_add(p_a[1], p_b[1], p_s[1]));
        drive_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        serve_resp(0);
        check("wrap_count", op_count, 0);

        // Randomized traffic
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && ($urandom_range(0, 1) == 1)) new_op(i);
            end
            drive_req(0, p_v[0], p_a[0], p_b[0], p_s[0]);
            drive_req(1, p_v[1], p_a[1], p_b[1], p_s[1]);
            if (!p_v[0] && !p_v[1]) begin
                #1;
                check("noreq_rdy0", req0_ready, 0);
                check("noreq_rdy1", req1_ready, 0);
                tick();
            end else begin
                w = winner(p_v[0], p_v[1]);
                do_accept(w, ref_add(p_a[w], p_b[w], p_s[w]));
                p_v[w] = 1'b0;
                drive_req(w, 1'b0, p_a[w], p_b[w], p_s[w]);
                serve_resp($urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
